// File: rtl/md_pkg.sv
// Shared multiply/divide opcodes, default latencies and start decode.
// MD_UNIT_MADD_EN enables the MADD/MSUB accumulate opcodes.
package md_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;
  localparam logic [3:0] MD_MADD  = 4'd9;
  localparam logic [3:0] MD_MADDU = 4'd10;
  localparam logic [3:0] MD_MSUB  = 4'd11;
  localparam logic [3:0] MD_MSUBU = 4'd12;

  localparam int unsigned MD_MULT_CYCLES = 5;
  localparam int unsigned MD_DIV_CYCLES  = 10;

  function automatic logic md_is_start(input logic [3:0] op);
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: return 1'b1;
`ifdef MD_UNIT_MADD_EN
      MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/md_divider.sv
// Combinational signed/unsigned 32-bit divide with divide-by-zero flag.
// Quotient truncates toward zero; remainder follows the dividend sign.
module md_divider (
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        is_signed,
  output logic [31:0] quo,
  output logic [31:0] rem,
  output logic        div0
);

  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] q_u;
  logic [31:0] r_u;

  always_comb begin
    neg_a = is_signed & dividend[31];
    neg_b = is_signed & divisor[31];
    mag_a = neg_a ? -dividend : dividend;
    mag_b = neg_b ? -divisor : divisor;
    div0  = (divisor == 32'd0);
    q_u   = '0;
    r_u   = '0;
    if (!div0) begin
      q_u = mag_a / mag_b;
      r_u = mag_a % mag_b;
    end
    quo = (neg_a ^ neg_b) ? -q_u : q_u;
    rem = neg_a ? -r_u : r_u;
  end

endmodule

// File: rtl/md_unit.sv
// EX-stage multi-cycle multiply/divide unit owning the HI/LO pair.
// MD_UNIT_MADD_EN builds the 64-bit MADD/MSUB accumulate path.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] md_rd,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   pend_q, pend_d;
  logic          pend_ok_q, pend_ok_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  logic          mul_sgn;
  logic [63:0]   prod;
  logic [31:0]   quo;
  logic [31:0]   rem;
  logic          div0;

  md_divider u_div (
    .dividend  (rs_val),
    .divisor   (rt_val),
    .is_signed (md_op == MD_DIV),
    .quo       (quo),
    .rem       (rem),
    .div0      (div0)
  );

  // One 64x64 multiplier serves both signednesses via sign extension
  always_comb begin
    mul_sgn = (md_op == MD_MULT) || (md_op == MD_MADD) ||
              (md_op == MD_MSUB);
    prod = {{32{mul_sgn & rs_val[31]}}, rs_val} *
           {{32{mul_sgn & rt_val[31]}}, rt_val};
  end

`ifdef MD_UNIT_MADD_EN
  logic [63:0] acc_add;
  logic [63:0] acc_sub;

  always_comb begin
    acc_add = {hi_q, lo_q} + prod;
    acc_sub = {hi_q, lo_q} - prod;
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pend_ok_d = pend_ok_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (state_q == S_BUSY) begin
      if (cnt_q == '0) begin
        state_d = S_IDLE;
        if (pend_ok_q) begin
          hi_d = pend_q[63:32];
          lo_d = pend_q[31:0];
        end
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end else if (en) begin
      if (md_is_start(md_op)) begin
        state_d   = S_BUSY;
        pend_ok_d = 1'b1;
        cnt_d     = CW'(MULT_CYCLES - 1);
        case (md_op)
          MD_DIV, MD_DIVU: begin
            pend_d    = {rem, quo};
            pend_ok_d = ~div0;
            cnt_d     = CW'(DIV_CYCLES - 1);
          end
`ifdef MD_UNIT_MADD_EN
          MD_MADD, MD_MADDU: pend_d = acc_add;
          MD_MSUB, MD_MSUBU: pend_d = acc_sub;
`endif
          default: pend_d = prod;
        endcase
      end else if (md_op == MD_MTHI) begin
        hi_d = rs_val;
      end else if (md_op == MD_MTLO) begin
        lo_d = rs_val;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pend_q    <= '0;
      pend_ok_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_ok_q <= pend_ok_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  always_comb begin
    md_rd = '0;
    if (md_op == MD_MFHI) md_rd = hi_q;
    else if (md_op == MD_MFLO) md_rd = lo_q;
  end

  assign busy = (state_q == S_BUSY);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed table, corner sequences,
// and random ops against an arithmetic reference model.
module tb_md_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  md_op = MD_NONE;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        busy;
  logic [31:0] md_rd;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad = 0;
  logic [31:0] ref_hi = '0;
  logic [31:0] ref_lo = '0;

  md_unit dut (
    .clk    (clk),
    .reset  (rst_n),
    .en     (en),
    .md_op  (md_op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .md_rd  (md_rd),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
    int          cyc;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural HI/LO pair
  task automatic model(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int cyc);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    cyc = 0;
    case (op)
      MD_MULT: begin
        p = 64'(sa * sb);
        {ref_hi, ref_lo} = p;
        cyc = MD_MULT_CYCLES;
      end
      MD_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        {ref_hi, ref_lo} = p;
        cyc = MD_MULT_CYCLES;
      end
      MD_DIV: begin
        cyc = MD_DIV_CYCLES;
        if (b != 0) begin
          q = sa / sb;
          r = sa % sb;
          ref_lo = q[31:0];
          ref_hi = r[31:0];
        end
      end
      MD_DIVU: begin
        cyc = MD_DIV_CYCLES;
        if (b != 0) begin
          ref_lo = a / b;
          ref_hi = a % b;
        end
      end
      MD_MTHI: ref_hi = a;
      MD_MTLO: ref_lo = a;
`ifdef MD_UNIT_MADD_EN
      MD_MADD: begin
        p = {ref_hi, ref_lo} + 64'(sa * sb);
        {ref_hi, ref_lo} = p;
        cyc = MD_MULT_CYCLES;
      end
      MD_MADDU: begin
        p = {ref_hi, ref_lo} + {32'd0, a} * {32'd0, b};
        {ref_hi, ref_lo} = p;
        cyc = MD_MULT_CYCLES;
      end
      MD_MSUB: begin
        p = {ref_hi, ref_lo} - 64'(sa * sb);
        {ref_hi, ref_lo} = p;
        cyc = MD_MULT_CYCLES;
      end
      MD_MSUBU: begin
        p = {ref_hi, ref_lo} - {32'd0, a} * {32'd0, b};
        {ref_hi, ref_lo} = p;
        cyc = MD_MULT_CYCLES;
      end
`endif
      default: ;
    endcase
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    en = 1'b1;
    md_op = op;
    rs_val = a;
    rt_val = b;
    @(negedge clk);
    en = 1'b0;
    md_op = MD_NONE;
  endtask

  task automatic run(input string name, input logic [3:0] op,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] ehi, input logic [31:0] elo,
                     input int cyc);
    int n;
    issue(op, a, b);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk({name, ".busy_cycles"}, 32'(n), 32'(cyc));
    chk({name, ".hi"}, hi, ehi);
    chk({name, ".lo"}, lo, elo);
    en = 1'b1;
    md_op = MD_MFHI;
    #1;
    chk({name, ".mfhi"}, md_rd, ehi);
    md_op = MD_MFLO;
    #1;
    chk({name, ".mflo"}, md_rd, elo);
    en = 1'b0;
    md_op = MD_NONE;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    int n;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0] op;
    logic [3:0] ops[12];

    tbl.push_back(vec_t'{"mult", MD_MULT, 32'hFFFFFFFE, 32'd3,
                         32'hFFFFFFFF, 32'hFFFFFFFA, 5});
    tbl.push_back(vec_t'{"multu", MD_MULTU, 32'hFFFFFFFE, 32'd3,
                         32'h00000002, 32'hFFFFFFFA, 5});
    tbl.push_back(vec_t'{"divu", MD_DIVU, 32'd7, 32'd2,
                         32'd1, 32'd3, 10});
    tbl.push_back(vec_t'{"div_neg", MD_DIV, 32'hFFFFFFF9, 32'd2,
                         32'hFFFFFFFF, 32'hFFFFFFFD, 10});
    tbl.push_back(vec_t'{"div_zero", MD_DIV, 32'h12345678, 32'd0,
                         32'hFFFFFFFF, 32'hFFFFFFFD, 10});
    tbl.push_back(vec_t'{"div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF,
                         32'd0, 32'h80000000, 10});
    tbl.push_back(vec_t'{"mtlo", MD_MTLO, 32'd1, 32'd0,
                         32'd0, 32'd1, 0});
    tbl.push_back(vec_t'{"mthi", MD_MTHI, 32'd0, 32'd0,
                         32'd0, 32'd1, 0});
`ifdef MD_UNIT_MADD_EN
    tbl.push_back(vec_t'{"madd", MD_MADD, 32'd2, 32'd3,
                         32'd0, 32'd7, 5});
`else
    tbl.push_back(vec_t'{"madd_off", MD_MADD, 32'd2, 32'd3,
                         32'd0, 32'd1, 0});
`endif
    tbl.push_back(vec_t'{"op13", 4'd13, 32'd9, 32'd9,
                         tbl[$].ehi, tbl[$].elo, 0});
    tbl.push_back(vec_t'{"op15", 4'd15, 32'd9, 32'd9,
                         tbl[$].ehi, tbl[$].elo, 0});

    #1;
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.hi", hi, 32'd0);
    chk("reset.lo", lo, 32'd0);
    chk("reset.md_rd", md_rd, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      model(tbl[i].op, tbl[i].a, tbl[i].b, c);
      run(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b,
          tbl[i].ehi, tbl[i].elo, tbl[i].cyc);
    end

    // Ops presented while busy must be ignored
    a = $urandom;
    b = $urandom;
    model(MD_MULT, a, b, c);
    issue(MD_MULT, a, b);
    n = 0;
    for (int k = 0; k < 4; k++) begin
      if (busy) n++;
      en = (k < 3);
      rs_val = 32'h1234;
      rt_val = 32'd7;
      case (k)
        0: md_op = MD_MTHI;
        1: md_op = MD_MULT;
        2: md_op = MD_MTLO;
        default: md_op = MD_NONE;
      endcase
      @(negedge clk);
    end
    en = 1'b0;
    md_op = MD_NONE;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("ignore.busy_cycles", 32'(n), 32'd5);
    chk("ignore.hi", hi, ref_hi);
    chk("ignore.lo", lo, ref_lo);

    // MTHI then MFHI in the very next cycle
    issue(MD_MTHI, 32'hCAFE0001, 32'd0);
    ref_hi = 32'hCAFE0001;
    en = 1'b1;
    md_op = MD_MFHI;
    #1;
    chk("mthi_mfhi.md_rd", md_rd, 32'hCAFE0001);
    en = 1'b0;
    md_op = MD_NONE;

    // Asynchronous reset in the middle of a divide
    issue(MD_DIV, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    chk("rst_mid.busy_before", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid.busy", 32'(busy), 32'd0);
    chk("rst_mid.hi", hi, 32'd0);
    chk("rst_mid.lo", lo, 32'd0);
    ref_hi = '0;
    ref_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid.busy_after", 32'(busy), 32'd0);
    chk("rst_mid.hi_after", hi, 32'd0);
    model(MD_MULTU, 32'h10001, 32'h30003, c);
    run("rst_multu", MD_MULTU, 32'h10001, 32'h30003, ref_hi, ref_lo, c);

    ops = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO,
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU, MD_MFHI, 4'd14};
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 11)];
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 9) == 0) begin
        a = 32'h80000000;
        b = 32'hFFFFFFFF;
      end
      model(op, a, b, c);
      run($sformatf("rand%0d_op%0d", i, op), op, a, b, ref_hi, ref_lo, c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
